// File: rtl/writeback_sequencer.sv
// Write-back stage controller: registers single-beat GPR writes, assembles
// multi-beat RET/RTI stack pops into an atomic PC (and CCR) load, and passes
// SP updates straight through.  All outputs are registered.
module writeback_sequencer #(
    parameter int REG_SIZE   = 16,
    parameter int CCR_SIZE   = 16,
    parameter int REG_NUMBER = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [3:0]            in_wr_addr,
    input  logic [REG_SIZE-1:0]   in_data,
    input  logic                  in_sp_valid,
    input  logic [31:0]           in_sp_data,
    output logic                  Data_write1,
    output logic [3:0]            write_addr1,
    output logic [REG_SIZE-1:0]   write_data1,
    output logic                  sp_write,
    output logic [31:0]           write_sp_data,
    output logic                  pc_load,
    output logic [2*REG_SIZE-1:0] write_pc_data,
    output logic                  ccr_load,
    output logic [CCR_SIZE-1:0]   write_ccr,
    output logic                  busy,
    output logic                  addr_err
);

    typedef enum logic [1:0] {IDLE, RET_HI, RTI_LO, RTI_HI} state_t;

    // Address compare is done one bit wider so REG_NUMBER = 16 still works.
    localparam logic [4:0] REG_LIMIT = 5'(REG_NUMBER);

    state_t                state_q, state_d;
    logic [REG_SIZE-1:0]   pc_lo_q, pc_lo_d;
    logic [CCR_SIZE-1:0]   ccr_hold_q, ccr_hold_d;
    logic                  data_write1_q, data_write1_d;
    logic [3:0]            write_addr1_q, write_addr1_d;
    logic [REG_SIZE-1:0]   write_data1_q, write_data1_d;
    logic                  sp_write_q, sp_write_d;
    logic [31:0]           write_sp_data_q, write_sp_data_d;
    logic                  pc_load_q, pc_load_d;
    logic [2*REG_SIZE-1:0] write_pc_data_q, write_pc_data_d;
    logic                  ccr_load_q, ccr_load_d;
    logic [CCR_SIZE-1:0]   write_ccr_q, write_ccr_d;
    logic                  addr_err_q, addr_err_d;
    logic                  accept;

    // The pc_load cycle is a flush bubble: nothing is accepted then.
    assign in_ready = ~rst & ~pc_load_q;
    assign accept   = in_valid & in_ready;

    assign Data_write1   = data_write1_q;
    assign write_addr1   = write_addr1_q;
    assign write_data1   = write_data1_q;
    assign sp_write      = sp_write_q;
    assign write_sp_data = write_sp_data_q;
    assign pc_load       = pc_load_q;
    assign write_pc_data = write_pc_data_q;
    assign ccr_load      = ccr_load_q;
    assign write_ccr     = write_ccr_q;
    assign busy          = (state_q != IDLE);
    assign addr_err      = addr_err_q;

    // Next-state, pop latches and registered outputs; strobes default low, values hold.
    always_comb begin
        state_d         = state_q;
        pc_lo_d         = pc_lo_q;
        ccr_hold_d      = ccr_hold_q;
        data_write1_d   = 1'b0;
        write_addr1_d   = write_addr1_q;
        write_data1_d   = write_data1_q;
        sp_write_d      = 1'b0;
        write_sp_data_d = write_sp_data_q;
        pc_load_d       = 1'b0;
        write_pc_data_d = write_pc_data_q;
        ccr_load_d      = 1'b0;
        write_ccr_d     = write_ccr_q;
        addr_err_d      = 1'b0;

        if (accept) begin
            // SP path runs alongside whatever the FSM does with this beat.
            if (in_sp_valid) begin
                sp_write_d      = 1'b1;
                write_sp_data_d = in_sp_data;
            end
            case (state_q)
                IDLE: begin
                    case (in_op)
                        2'b01: begin
                            if ({1'b0, in_wr_addr} < REG_LIMIT) begin
                                data_write1_d = 1'b1;
                                write_addr1_d = in_wr_addr;
                                write_data1_d = in_data;
                            end else begin
                                addr_err_d = 1'b1;
                            end
                        end
                        2'b10: begin
                            pc_lo_d = in_data;
                            state_d = RET_HI;
                        end
                        2'b11: begin
                            ccr_hold_d = CCR_SIZE'(in_data);
                            state_d    = RTI_LO;
                        end
                        default: ;
                    endcase
                end
                RTI_LO: begin
                    pc_lo_d = in_data;
                    state_d = RTI_HI;
                end
                RET_HI: begin
                    pc_load_d       = 1'b1;
                    write_pc_data_d = {in_data, pc_lo_q};
                    state_d         = IDLE;
                end
                RTI_HI: begin
                    pc_load_d       = 1'b1;
                    ccr_load_d      = 1'b1;
                    write_pc_data_d = {in_data, pc_lo_q};
                    write_ccr_d     = ccr_hold_q;
                    state_d         = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; reset discards any partial pop sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            pc_lo_q         <= '0;
            ccr_hold_q      <= '0;
            data_write1_q   <= 1'b0;
            write_addr1_q   <= '0;
            write_data1_q   <= '0;
            sp_write_q      <= 1'b0;
            write_sp_data_q <= '0;
            pc_load_q       <= 1'b0;
            write_pc_data_q <= '0;
            ccr_load_q      <= 1'b0;
            write_ccr_q     <= '0;
            addr_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_lo_q         <= pc_lo_d;
            ccr_hold_q      <= ccr_hold_d;
            data_write1_q   <= data_write1_d;
            write_addr1_q   <= write_addr1_d;
            write_data1_q   <= write_data1_d;
            sp_write_q      <= sp_write_d;
            write_sp_data_q <= write_sp_data_d;
            pc_load_q       <= pc_load_d;
            write_pc_data_q <= write_pc_data_d;
            ccr_load_q      <= ccr_load_d;
            write_ccr_q     <= write_ccr_d;
            addr_err_q      <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Bench for writeback_sequencer: directed vector table, hand-written reset
// sequence, then random traffic checked against a queue-based pop model.
module tb_writeback_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [3:0]  in_wr_addr;
    logic [15:0] in_data;
    logic        in_sp_valid;
    logic [31:0] in_sp_data;
    logic        Data_write1;
    logic [3:0]  write_addr1;
    logic [15:0] write_data1;
    logic        sp_write;
    logic [31:0] write_sp_data;
    logic        pc_load;
    logic [31:0] write_pc_data;
    logic        ccr_load;
    logic [15:0] write_ccr;
    logic        busy;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    writeback_sequencer #(.REG_SIZE(16), .CCR_SIZE(16), .REG_NUMBER(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_wr_addr(in_wr_addr), .in_data(in_data),
        .in_sp_valid(in_sp_valid), .in_sp_data(in_sp_data),
        .Data_write1(Data_write1), .write_addr1(write_addr1), .write_data1(write_data1),
        .sp_write(sp_write), .write_sp_data(write_sp_data),
        .pc_load(pc_load), .write_pc_data(write_pc_data),
        .ccr_load(ccr_load), .write_ccr(write_ccr),
        .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dw;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        err;
        logic        pcl;
        logic [31:0] pc;
        logic        ccrl;
        logic [15:0] ccr;
        logic        busy;
        logic        rdy;
        logic        spw;
        logic [31:0] spd;
    } exp_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        spv;
        logic [31:0] spd;
        exp_t        e;
    } vec_t;

    // Reference model: words popped so far in the current RET/RTI sequence.
    exp_t        m;
    logic [15:0] words[$];
    int          need;

    function automatic vec_t mk(
        input logic v, input logic [1:0] op, input logic [3:0] a, input logic [15:0] d,
        input logic spv, input logic [31:0] spdi,
        input logic dw, input logic [3:0] wa, input logic [15:0] wd, input logic err,
        input logic pcl, input logic [31:0] pc, input logic ccrl, input logic [15:0] ccr,
        input logic bsy, input logic rdy, input logic spw, input logic [31:0] spdo);
        vec_t r;
        r.valid = v; r.op = op; r.addr = a; r.data = d; r.spv = spv; r.spd = spdi;
        r.e.dw = dw; r.e.wa = wa; r.e.wd = wd; r.e.err = err;
        r.e.pcl = pcl; r.e.pc = pc; r.e.ccrl = ccrl; r.e.ccr = ccr;
        r.e.busy = bsy; r.e.rdy = rdy; r.e.spw = spw; r.e.spd = spdo;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".Data_write1"},   32'(Data_write1),   32'(e.dw));
        chk({tag, ".write_addr1"},   32'(write_addr1),   32'(e.wa));
        chk({tag, ".write_data1"},   32'(write_data1),   32'(e.wd));
        chk({tag, ".addr_err"},      32'(addr_err),      32'(e.err));
        chk({tag, ".pc_load"},       32'(pc_load),       32'(e.pcl));
        chk({tag, ".write_pc_data"}, write_pc_data,      e.pc);
        chk({tag, ".ccr_load"},      32'(ccr_load),      32'(e.ccrl));
        chk({tag, ".write_ccr"},     32'(write_ccr),     32'(e.ccr));
        chk({tag, ".busy"},          32'(busy),          32'(e.busy));
        chk({tag, ".in_ready"},      32'(in_ready),      32'(e.rdy));
        chk({tag, ".sp_write"},      32'(sp_write),      32'(e.spw));
        chk({tag, ".write_sp_data"}, write_sp_data,      e.spd);
    endtask

    task automatic model_step(input vec_t v);
        logic acc;
        acc = v.valid && !m.pcl;
        m.dw = 0; m.err = 0; m.pcl = 0; m.ccrl = 0; m.spw = 0;
        if (acc) begin
            if (v.spv) begin m.spw = 1; m.spd = v.spd; end
            if (words.size() == 0) begin
                case (v.op)
                    2'd1: if (v.addr < 4'd8) begin m.dw = 1; m.wa = v.addr; m.wd = v.data; end
                          else m.err = 1;
                    2'd2: begin need = 2; words.push_back(v.data); end
                    2'd3: begin need = 3; words.push_back(v.data); end
                    default: ;
                endcase
            end else begin
                words.push_back(v.data);
                if (words.size() == need) begin
                    m.pcl = 1;
                    m.pc  = {words[need-1], words[need-2]};
                    if (need == 3) begin m.ccrl = 1; m.ccr = words[0]; end
                    words.delete();
                end
            end
        end
        m.busy = (words.size() != 0);
        m.rdy  = !m.pcl;
    endtask

    // Drive one beat (called just after a posedge), advance the model, settle past the next edge.
    task automatic apply(input vec_t v);
        in_valid = v.valid; in_op = v.op; in_wr_addr = v.addr; in_data = v.data;
        in_sp_valid = v.spv; in_sp_data = v.spd;
        model_step(v);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tag);
        #3;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_all({tag, ".rst"}, '0);
        m = '0; words.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        m.rdy = 1'b1;
        chk({tag, ".ready_after_release"}, 32'(in_ready), 32'd1);
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        rst = 1'b1; in_valid = 0; in_op = 0; in_wr_addr = 0; in_data = 0;
        in_sp_valid = 0; in_sp_data = 0;
        m = '0; need = 0;
        @(posedge clk); #1;
        do_reset("init");

        //              v  op    a   data      spv spd        dw wa  wd        err pcl pc             ccrl ccr      bsy rdy spw spd
        tbl[0]  = mk(1, 2'd1, 3, 16'hBEEF, 0, 0,          1, 3, 16'hBEEF, 0, 0, 32'h0,         0, 16'h0000, 0, 1, 0, 0);
        tbl[1]  = mk(1, 2'd1, 8, 16'h1111, 0, 0,          0, 3, 16'hBEEF, 1, 0, 32'h0,         0, 16'h0000, 0, 1, 0, 0);
        tbl[2]  = mk(1, 2'd2, 0, 16'h0020, 1, 32'd2046,   0, 3, 16'hBEEF, 0, 0, 32'h0,         0, 16'h0000, 1, 1, 1, 32'd2046);
        tbl[3]  = mk(0, 2'd0, 0, 16'h0000, 0, 0,          0, 3, 16'hBEEF, 0, 0, 32'h0,         0, 16'h0000, 1, 1, 0, 32'd2046);
        tbl[4]  = mk(0, 2'd0, 0, 16'h0000, 0, 0,          0, 3, 16'hBEEF, 0, 0, 32'h0,         0, 16'h0000, 1, 1, 0, 32'd2046);
        tbl[5]  = mk(1, 2'd1, 2, 16'h0001, 0, 0,          0, 3, 16'hBEEF, 0, 1, 32'h0001_0020, 0, 16'h0000, 0, 0, 0, 32'd2046);
        tbl[6]  = mk(1, 2'd1, 1, 16'h7777, 1, 32'h55,     0, 3, 16'hBEEF, 0, 0, 32'h0001_0020, 0, 16'h0000, 0, 1, 0, 32'd2046);
        tbl[7]  = mk(1, 2'd3, 0, 16'h0005, 0, 0,          0, 3, 16'hBEEF, 0, 0, 32'h0001_0020, 0, 16'h0000, 1, 1, 0, 32'd2046);
        tbl[8]  = mk(1, 2'd0, 0, 16'h1234, 0, 0,          0, 3, 16'hBEEF, 0, 0, 32'h0001_0020, 0, 16'h0000, 1, 1, 0, 32'd2046);
        tbl[9]  = mk(1, 2'd2, 0, 16'h0000, 0, 0,          0, 3, 16'hBEEF, 0, 1, 32'h0000_1234, 1, 16'h0005, 0, 0, 0, 32'd2046);
        tbl[10] = mk(0, 2'd0, 0, 16'h0000, 0, 0,          0, 3, 16'hBEEF, 0, 0, 32'h0000_1234, 0, 16'h0005, 0, 1, 0, 32'd2046);
        tbl[11] = mk(1, 2'd0, 0, 16'h0000, 1, 32'h12345678, 0, 3, 16'hBEEF, 0, 0, 32'h0000_1234, 0, 16'h0005, 0, 1, 1, 32'h12345678);

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i]);
            check_all($sformatf("vec%0d", i), tbl[i].e);
        end

        // Reset in the middle of an RTI sequence, then a normal REG write.
        apply(mk(1, 2'd3, 0, 16'h0009, 0, 0, 0,0,0,0,0,0,0,0,0,0,0,0));
        apply(mk(1, 2'd0, 0, 16'h4321, 0, 0, 0,0,0,0,0,0,0,0,0,0,0,0));
        chk("rti_mid.busy", 32'(busy), 32'd1);
        do_reset("rti_mid");
        apply(mk(1, 2'd1, 5, 16'hABCD, 0, 0, 0,0,0,0,0,0,0,0,0,0,0,0));
        chk("post_rst.Data_write1", 32'(Data_write1), 32'd1);
        chk("post_rst.write_addr1", 32'(write_addr1), 32'd5);
        chk("post_rst.write_data1", 32'(write_data1), 32'hABCD);
        chk("post_rst.busy",        32'(busy),        32'd0);
        apply(mk(1, 2'd0, 0, 16'h0000, 0, 0, 0,0,0,0,0,0,0,0,0,0,0,0));
        chk("post_rst.pc_load",  32'(pc_load),  32'd0);
        chk("post_rst.ccr_load", 32'(ccr_load), 32'd0);
        chk("post_rst.busy2",    32'(busy),     32'd0);

        // Random traffic against the model, with occasional mid-cycle resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) do_reset("rand");
            rv = '0;
            rv.valid = ($urandom_range(0, 9) < 7);
            rv.op    = 2'($urandom_range(0, 3));
            rv.addr  = 4'($urandom_range(0, 15));
            rv.data  = 16'($urandom);
            rv.spv   = ($urandom_range(0, 3) == 0);
            rv.spd   = $urandom;
            apply(rv);
            check_all($sformatf("rand%0d", n), m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
